fib_sequencer: RTL and testbench

FIB_SEQUENCER -- requirements
Module: fib_sequencer

---
 rtl/fib_pkg.sv | 20 ++
 rtl/fib_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fib_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: ALU opcodes, data width, FSM states.
package fib_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned MODE_W = 4;

   localparam logic [MODE_W-1:0] ALU_ADD = 4'b0011;
   localparam logic [MODE_W-1:0] ALU_SUB = 4'b0100;
   localparam logic [MODE_W-1:0] ALU_AND = 4'b0101;
   localparam logic [MODE_W-1:0] ALU_OR  = 4'b0110;
   localparam logic [MODE_W-1:0] ALU_NOT = 4'b1111;
   localparam logic [MODE_W-1:0] ALU_CLR = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fib_state_t;

endpackage

// File: rtl/fib_sequencer.sv
// Fibonacci term sequencer driving an external ALU: emits n terms, one per cycle.
// Optional feature macro FIB_OVF_STOP_EN: stop the run (and raise sticky ovf)
// before emitting the first term whose value wrapped modulo 256.
// All outputs are registered; they are computed from the next-state values so
// they line up with the state the FSM enters on each edge.
module fib_sequencer
   import fib_pkg::*;
#(
   parameter int unsigned N_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N_W-1:0]    n,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [MODE_W-1:0] alu_mode,
   input  logic [DATA_W-1:0] alu_s,
   output logic [DATA_W-1:0] term_out,
   output logic              term_valid,
   output logic [N_W-1:0]    term_idx,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   fib_state_t        state, state_d;
   logic [DATA_W-1:0] prev, prev_d;
   logic [DATA_W-1:0] curr, curr_d;
   logic [N_W-1:0]    cnt, cnt_d;
   logic [N_W-1:0]    n_lat, n_lat_d;

   logic [DATA_W-1:0] alu_a_d, alu_b_d, term_out_d;
   logic [MODE_W-1:0] alu_mode_d;
   logic [N_W-1:0]    term_idx_d;
   logic              term_valid_d, busy_d, done_d;

`ifdef FIB_OVF_STOP_EN
   logic prev_wrap, prev_wrap_d;
   logic curr_wrap, curr_wrap_d;
   logic ovf_d;
`else
   assign ovf = 1'b0;
`endif

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         prev       <= '0;
         curr       <= '0;
         cnt        <= '0;
         n_lat      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_mode   <= ALU_CLR;
         term_out   <= '0;
         term_idx   <= '0;
         term_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef FIB_OVF_STOP_EN
         prev_wrap  <= 1'b0;
         curr_wrap  <= 1'b0;
         ovf        <= 1'b0;
`endif
      end else begin
         state      <= state_d;
         prev       <= prev_d;
         curr       <= curr_d;
         cnt        <= cnt_d;
         n_lat      <= n_lat_d;
         alu_a      <= alu_a_d;
         alu_b      <= alu_b_d;
         alu_mode   <= alu_mode_d;
         term_out   <= term_out_d;
         term_idx   <= term_idx_d;
         term_valid <= term_valid_d;
         busy       <= busy_d;
         done       <= done_d;
`ifdef FIB_OVF_STOP_EN
         prev_wrap  <= prev_wrap_d;
         curr_wrap  <= curr_wrap_d;
         ovf        <= ovf_d;
`endif
      end
   end

   // Next-state, datapath update and next-output decode.
   always_comb begin
      state_d      = state;
      prev_d       = prev;
      curr_d       = curr;
      cnt_d        = cnt;
      n_lat_d      = n_lat;
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_mode_d   = ALU_CLR;
      term_out_d   = '0;
      term_idx_d   = '0;
      term_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
`ifdef FIB_OVF_STOP_EN
      prev_wrap_d  = prev_wrap;
      curr_wrap_d  = curr_wrap;
      ovf_d        = ovf;
`endif

      case (state)
         ST_IDLE: begin
            if (start) begin
`ifdef FIB_OVF_STOP_EN
               ovf_d = 1'b0;
`endif
               if (n != '0) begin
                  prev_d  = '0;
                  curr_d  = DATA_W'(1);
                  cnt_d   = '0;
                  n_lat_d = n;
`ifdef FIB_OVF_STOP_EN
                  prev_wrap_d = 1'b0;
                  curr_wrap_d = 1'b0;
`endif
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            prev_d = curr;
            curr_d = alu_s;
            cnt_d  = cnt + N_W'(1);
            if (cnt == n_lat - N_W'(1)) begin
               state_d = ST_DONE;
            end
`ifdef FIB_OVF_STOP_EN
            // Wrap flags travel with the terms so each term knows if it wrapped.
            curr_wrap_d = (alu_s < curr);
            prev_wrap_d = curr_wrap;
            if (prev_wrap) begin
               ovf_d   = 1'b1;
               state_d = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d == ST_RUN) begin
         alu_a_d      = prev_d;
         alu_b_d      = curr_d;
         alu_mode_d   = ALU_ADD;
         term_out_d   = prev_d;
         term_idx_d   = cnt_d;
         term_valid_d = 1'b1;
         busy_d       = 1'b1;
`ifdef FIB_OVF_STOP_EN
         // A wrapped term at the head of the pipe is never shown.
         if (prev_wrap_d) begin
            term_valid_d = 1'b0;
         end
`endif
      end
      done_d = (state_d == ST_DONE);
   end

endmodule

// File: tb/tb_fib_sequencer.sv
// Self-checking bench for fib_sequencer with a behavioural ALU beside it.
`timescale 1ns/1ps
module tb_fib_sequencer;
   import fib_pkg::*;

   localparam int unsigned N_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [N_W-1:0]    n;
   logic [7:0]        alu_a, alu_b, alu_s, term_out;
   logic [3:0]        alu_mode;
   logic              term_valid;
   logic [N_W-1:0]    term_idx;
   logic              busy, done, ovf;

   typedef struct packed {
      logic [7:0]     val;
      logic [N_W-1:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fib_sequencer #(.N_W(N_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n(n),
      .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_s(alu_s),
      .term_out(term_out), .term_valid(term_valid), .term_idx(term_idx),
      .busy(busy), .done(done), .ovf(ovf)
   );

   // Enclosing-level ALU model.
   always_comb begin
      case (alu_mode)
         ALU_ADD: alu_s = alu_a + alu_b;
         ALU_SUB: alu_s = alu_a - alu_b;
         ALU_AND: alu_s = alu_a & alu_b;
         ALU_OR:  alu_s = alu_a | alu_b;
         ALU_NOT: alu_s = ~alu_a;
         default: alu_s = 8'd0;
      endcase
   end

   // Push the expected emitted terms for a run of cnt terms; returns expected ovf.
   function automatic bit model_push(input int cnt);
      logic [7:0] p2, p1, t;
      bit eo;
      eo = 1'b0;
      p2 = 8'd0;
      p1 = 8'd0;
      for (int i = 0; i < cnt; i++) begin
         if (i == 0)      t = 8'd0;
         else if (i == 1) t = 8'd1;
         else begin
            t = p2 + p1;
`ifdef FIB_OVF_STOP_EN
            if (t < p1) begin
               eo = 1'b1;
               break;
            end
`endif
         end
         exp_q.push_back('{val: t, idx: N_W'(i)});
         p2 = p1;
         p1 = t;
      end
      return eo;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      n     = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (term_out !== 8'd0 || term_idx !== '0) begin
         errors++;
         $display("FAIL reset_term: got out %0d idx %0d, expected 0 0", term_out, term_idx);
      end
      checks++;
      if (term_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got valid %b busy %b done %b ovf %b, expected 0000",
                  term_valid, busy, done, ovf);
      end
      checks++;
      if (alu_a !== 8'd0 || alu_b !== 8'd0 || alu_mode !== 4'b1010) begin
         errors++;
         $display("FAIL reset_alu: got a %0d b %0d mode %b, expected 0 0 1010", alu_a, alu_b, alu_mode);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_seq6();
      exp_t e;
      bit   fin;
      exp_q.delete();
      void'(model_push(6));
      start = 1'b1;
      n     = N_W'(6);
      fin   = 1'b0;
      for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == 0) begin
            checks++;
            if (ovf !== 1'b0 || alu_mode !== 4'b0011) begin
               errors++;
               $display("FAIL seq6_first: got ovf %b mode %b, expected 0 0011", ovf, alu_mode);
            end
         end
         if (term_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL seq6_extra: got idx %0d val %0d, expected no term", term_idx, term_out);
            end else begin
               e = exp_q.pop_front();
               if (term_out !== e.val || term_idx !== e.idx || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL seq6_term: got val %0d idx %0d busy %b, expected val %0d idx %0d busy 1",
                           term_out, term_idx, busy, e.val, e.idx);
               end
            end
         end
         if (done === 1'b1) begin
            fin = 1'b1;
            checks++;
            if (cyc != 6 || exp_q.size() != 0 || busy !== 1'b0 || term_valid !== 1'b0) begin
               errors++;
               $display("FAIL seq6_done: got cycle %0d left %0d busy %b valid %b, expected 6 0 0 0",
                        cyc, exp_q.size(), busy, term_valid);
            end
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL seq6_timeout: got no done, expected done within 40 cycles");
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || term_valid !== 1'b0) begin
         errors++;
         $display("FAIL seq6_after: got done %b busy %b valid %b, expected 000", done, busy, term_valid);
      end
   endtask

   task automatic test_n0();
      bit fin;
      start = 1'b1;
      n     = '0;
      fin   = 1'b0;
      for (int cyc = 0; cyc < 10 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (term_valid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL n0_term: got term idx %0d val %0d, expected none", term_idx, term_out);
         end
         if (done === 1'b1) begin
            fin = 1'b1;
            checks++;
            if (cyc != 0 || busy !== 1'b0 || ovf !== 1'b0) begin
               errors++;
               $display("FAIL n0_done: got cycle %0d busy %b ovf %b, expected 0 0 0", cyc, busy, ovf);
            end
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL n0_timeout: got no done, expected done after acceptance");
      end
      @(negedge clk);
   endtask

   task automatic test_n20();
      exp_t e;
      bit   fin, eo, ovf_early;
      exp_q.delete();
      eo        = model_push(20);
      ovf_early = 1'b0;
      start     = 1'b1;
      n         = N_W'(20);
      fin       = 1'b0;
      for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (done !== 1'b1 && ovf !== 1'b0) ovf_early = 1'b1;
         if (term_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL n20_extra: got idx %0d val %0d, expected no term", term_idx, term_out);
            end else begin
               e = exp_q.pop_front();
               if (term_out !== e.val || term_idx !== e.idx) begin
                  errors++;
                  $display("FAIL n20_term: got val %0d idx %0d, expected val %0d idx %0d",
                           term_out, term_idx, e.val, e.idx);
               end
            end
            if (term_idx == N_W'(13) || term_idx == N_W'(14) || term_idx == N_W'(15)) begin
               checks++;
               if ((term_idx == N_W'(13) && term_out !== 8'd233) ||
                   (term_idx == N_W'(14) && term_out !== 8'd121) ||
                   (term_idx == N_W'(15) && term_out !== 8'd98)) begin
                  errors++;
                  $display("FAIL n20_wrap_value: got idx %0d val %0d, expected 233/121/98 at 13/14/15",
                           term_idx, term_out);
               end
            end
         end
         if (done === 1'b1) begin
            fin = 1'b1;
            checks++;
            if (ovf !== eo || exp_q.size() != 0 || ovf_early) begin
               errors++;
               $display("FAIL n20_done: got ovf %b left %0d early_ovf %b, expected ovf %b left 0 early 0",
                        ovf, exp_q.size(), ovf_early, eo);
            end
`ifndef FIB_OVF_STOP_EN
            checks++;
            if (cyc != 20) begin
               errors++;
               $display("FAIL n20_len: got done at cycle %0d, expected 20", cyc);
            end
`endif
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL n20_timeout: got no done, expected done within 60 cycles");
      end
      repeat (3) @(negedge clk);
      checks++;
      if (ovf !== eo || busy !== 1'b0) begin
         errors++;
         $display("FAIL n20_sticky: got ovf %b busy %b in idle, expected ovf %b busy 0", ovf, busy, eo);
      end
   endtask

   task automatic test_ignore();
      exp_t e;
      bit   fin;
      exp_q.delete();
      void'(model_push(6));
      start = 1'b1;
      n     = N_W'(6);
      fin   = 1'b0;
      for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (term_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ign_extra: got idx %0d val %0d, expected no term", term_idx, term_out);
            end else begin
               e = exp_q.pop_front();
               if (term_out !== e.val || term_idx !== e.idx) begin
                  errors++;
                  $display("FAIL ign_term: got val %0d idx %0d, expected val %0d idx %0d",
                           term_out, term_idx, e.val, e.idx);
               end
            end
            if (term_idx == N_W'(2)) begin
               start = 1'b1;
               n     = N_W'(3);
            end
         end
         if (done === 1'b1) begin
            fin = 1'b1;
            start = 1'b1;
            checks++;
            if (cyc != 6 || exp_q.size() != 0) begin
               errors++;
               $display("FAIL ign_done: got cycle %0d left %0d, expected 6 0", cyc, exp_q.size());
            end
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL ign_timeout: got no done, expected done within 40 cycles");
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || term_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ign_done_start: got busy %b valid %b done %b, expected 000", busy, term_valid, done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || term_valid !== 1'b0) begin
         errors++;
         $display("FAIL ign_idle: got busy %b valid %b, expected 00", busy, term_valid);
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      bit   hit, fin;
      exp_q.delete();
      void'(model_push(6));
      start = 1'b1;
      n     = N_W'(6);
      hit   = 1'b0;
      for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (term_valid === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (term_out !== e.val || term_idx !== e.idx) begin
               errors++;
               $display("FAIL mrst_term: got val %0d idx %0d, expected val %0d idx %0d",
                        term_out, term_idx, e.val, e.idx);
            end
            if (term_idx == N_W'(3)) begin
               hit   = 1'b1;
               rst_n = 1'b0;
            end
         end
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL mrst_timeout: got no term idx 3, expected it within 20 cycles");
      end
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (term_out !== 8'd0 || term_idx !== '0 || term_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || ovf !== 1'b0 || alu_a !== 8'd0 || alu_b !== 8'd0 || alu_mode !== 4'b1010) begin
         errors++;
         $display("FAIL mrst_values: got out %0d idx %0d v%b b%b d%b o%b a %0d b %0d mode %b, expected idle reset values",
                  term_out, term_idx, term_valid, busy, done, ovf, alu_a, alu_b, alu_mode);
      end
      exp_q.delete();
      void'(model_push(4));
      start = 1'b1;
      n     = N_W'(4);
      fin   = 1'b0;
      for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (term_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL mrst_extra: got idx %0d val %0d, expected no term", term_idx, term_out);
            end else begin
               e = exp_q.pop_front();
               if (term_out !== e.val || term_idx !== e.idx) begin
                  errors++;
                  $display("FAIL mrst_restart: got val %0d idx %0d, expected val %0d idx %0d",
                           term_out, term_idx, e.val, e.idx);
               end
            end
         end
         if (done === 1'b1) begin
            fin = 1'b1;
            checks++;
            if (cyc != 4 || exp_q.size() != 0) begin
               errors++;
               $display("FAIL mrst_done: got cycle %0d left %0d, expected 4 0", cyc, exp_q.size());
            end
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL mrst_timeout2: got no done, expected done within 20 cycles");
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   fin;
      for (int r = 1; r <= 2; r++) begin
         exp_q.delete();
         void'(model_push(r));
         start = 1'b1;
         n     = N_W'(r);
         fin   = 1'b0;
         for (int cyc = 0; cyc < 10 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (term_valid === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL b2b_extra: got idx %0d val %0d, expected no term", term_idx, term_out);
               end else begin
                  e = exp_q.pop_front();
                  if (term_out !== e.val || term_idx !== e.idx) begin
                     errors++;
                     $display("FAIL b2b_term: got val %0d idx %0d, expected val %0d idx %0d",
                              term_out, term_idx, e.val, e.idx);
                  end
               end
            end
            if (done === 1'b1) begin
               fin = 1'b1;
               checks++;
               if (cyc != r || exp_q.size() != 0) begin
                  errors++;
                  $display("FAIL b2b_done: got cycle %0d left %0d, expected %0d 0", cyc, exp_q.size(), r);
               end
            end
         end
         if (!fin) begin
            checks++;
            errors++;
            $display("FAIL b2b_timeout: got no done, expected done within 10 cycles");
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_seq6();
      test_n0();
      test_n20();
      test_seq6();
      test_ignore();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
